// File: rtl/hv_pkg.sv
// Shared HPU hypervector types: rotate direction and the default word type.
package hv_pkg;

    typedef enum logic {ROT_R = 1'b0, ROT_L = 1'b1} rot_dir_t;

    localparam int HV_WIDTH = 32;
    typedef logic [HV_WIDTH-1:0] hv_word_t;

endpackage

// File: rtl/hv_rotate_stage.sv
// One pipeline stage of the right-rotate barrel: applies levels [LO,HI) and
// registers word, amount, last and valid with local bubble-collapsing load logic.
module hv_rotate_stage
    import hv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int LO    = 0,
    parameter int HI    = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output logic             out_last
);

    logic [WIDTH-1:0] rot;

    // Empty level range (LO >= HI) simply passes the word through.
    always_comb begin
        rot = in_data;
        for (int l = LO; l < HI; l++) begin
            if (in_amt[l])
                rot = (rot >> (1 << l)) | (rot << (WIDTH - (1 << l)));
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= rot;
                out_amt  <= in_amt;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/hv_rotate_pipe.sv
// Streaming cyclic rotator: left rotates are folded into right rotates at the
// input, then PIPE chained barrel stages finish the job under valid/ready flow.
module hv_rotate_pipe
    import hv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32,
    parameter int PIPE  = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH-1:0]          s_data,
    input  logic [AMT_W-1:0]          s_amt,
    input  logic                      s_dir,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WIDTH-1:0]          m_data,
    output logic                      m_last,
    output logic [$clog2(PIPE+1)-1:0] in_flight
);

    localparam int SHW = $clog2(WIDTH);
    localparam int L   = (SHW + PIPE - 1) / PIPE;

    logic [PIPE:0]            vld_pipe;
    logic [PIPE:0]            rdy_pipe;
    logic [PIPE:0][WIDTH-1:0] dat;
    logic [PIPE:0][SHW-1:0]   amt;
    logic [PIPE:0]            lst;
    logic [SHW-1:0]           a;
    logic [SHW-1:0]           a_neg;
    logic                     acc;
    logic                     emit;
    logic                     unused_amt;

    // Left by a == right by (WIDTH - a) mod WIDTH, which is just -a in SHW bits.
    assign a     = s_amt[SHW-1:0];
    assign a_neg = '0 - a;

    assign vld_pipe[0] = s_valid;
    assign dat[0]      = s_data;
    assign amt[0]      = (rot_dir_t'(s_dir) == ROT_L) ? a_neg : a;
    assign lst[0]      = s_last;
    assign s_ready     = rdy_pipe[0];

    assign rdy_pipe[PIPE] = m_ready;
    assign m_valid        = vld_pipe[PIPE];
    assign m_data         = dat[PIPE];
    assign m_last         = lst[PIPE];

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int LO = (k * L < SHW) ? k * L : SHW;
        localparam int HI = ((k + 1) * L < SHW) ? (k + 1) * L : SHW;

        hv_rotate_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .LO    (LO),
            .HI    (HI)
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (vld_pipe[k]),
            .in_ready  (rdy_pipe[k]),
            .in_data   (dat[k]),
            .in_amt    (amt[k]),
            .in_last   (lst[k]),
            .out_valid (vld_pipe[k+1]),
            .out_ready (rdy_pipe[k+1]),
            .out_data  (dat[k+1]),
            .out_amt   (amt[k+1]),
            .out_last  (lst[k+1])
        );
    end

    assign acc  = s_valid && s_ready;
    assign emit = m_valid && m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            in_flight <= '0;
        else if (acc && !emit)
            in_flight <= in_flight + 1'b1;
        else if (!acc && emit)
            in_flight <= in_flight - 1'b1;
    end

    assign unused_amt = ^{s_amt[AMT_W-1:SHW], amt[PIPE]};

endmodule

// File: tb/tb_hv_rotate_pipe.sv
// Self-checking bench for hv_rotate_pipe (WIDTH=32, PIPE=2) with a bit-level
// rotate model and a beat-order scoreboard.
module tb_hv_rotate_pipe;

    typedef struct {
        logic [31:0] data;
        logic [31:0] amt;
        logic        dir;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] s_amt;
    logic        s_dir;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [1:0]  in_flight;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t src_q[$];
    exp_t  exp_q[$];
    bit    vmode, rmode, rdy_fix, chk_lat;
    bit    hold_prev;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [31:0] last_out;

    hv_rotate_pipe #(.WIDTH(32), .AMT_W(32), .PIPE(2)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_amt(s_amt),
        .s_dir(s_dir), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    // Bit-level rotate: right moves in[i+a] to out[i], left moves in[i] to out[i+a].
    function automatic logic [31:0] ref_rot(logic [31:0] d, logic [31:0] amt, logic dir);
        int a;
        logic [31:0] r;
        a = int'(amt % 32);
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (!dir) r[i] = d[(i + a) % 32];
            else      r[(i + a) % 32] = d[i];
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [31:0] d, logic [31:0] a, logic dir, logic last);
        beat_t b;
        b.data = d; b.amt = a; b.dir = dir; b.last = last;
        src_q.push_back(b);
    endtask

    // One cycle: drive, sample/score on the falling edge, then take the rising edge.
    task automatic tick();
        bit   acc, emit;
        exp_t e;
        m_ready = rmode ? 1'($urandom_range(1)) : rdy_fix;
        if (src_q.size() > 0 && (!vmode || $urandom_range(1) == 1)) begin
            s_valid = 1'b1;
            s_data  = src_q[0].data;
            s_amt   = src_q[0].amt;
            s_dir   = src_q[0].dir;
            s_last  = src_q[0].last;
        end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
            s_amt   = $urandom;
            s_dir   = 1'($urandom_range(1));
            s_last  = 1'($urandom_range(1));
        end
        @(negedge clk);
        acc  = s_valid && s_ready;
        emit = m_valid && m_ready;
        chk("in_flight", 64'(in_flight), 64'(exp_q.size()));
        if (hold_prev) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data", 64'(m_data), 64'(hold_data));
            chk("hold_last", 64'(m_last), 64'(hold_last));
        end
        hold_prev = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
        if (m_valid && exp_q.size() == 0)
            chk("spurious_valid", 64'(m_valid), 64'd0);
        else if (emit) begin
            e = exp_q.pop_front();
            last_out = m_data;
            chk("m_data", 64'(m_data), 64'(e.data));
            chk("m_last", 64'(m_last), 64'(e.last));
            if (chk_lat) chk("latency", 64'(cyc - e.c), 64'd2);
        end
        if (acc) begin
            e.data = ref_rot(src_q[0].data, src_q[0].amt, src_q[0].dir);
            e.last = src_q[0].last;
            e.c    = cyc;
            exp_q.push_back(e);
            void'(src_q.pop_front());
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(string tag, int maxc);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_amt = '0; s_dir = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;
        vmode = 0; rmode = 0; rdy_fix = 1; chk_lat = 1; hold_prev = 0;
        #12;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_in_flight", 64'(in_flight), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        // Directed rotates with latency check
        push(32'h0000_00F1, 32'd4, 1'b0, 1'b0);
        drain("t1_drain", 20);
        chk("t1_r4", 64'(last_out), 64'h1000_000F);
        push(32'h0000_00F1, 32'd4, 1'b1, 1'b1);
        drain("t2a_drain", 20);
        chk("t2_l4", 64'(last_out), 64'h0000_0F10);
        push(32'h0000_00F1, 32'd36, 1'b0, 1'b0);
        drain("t2b_drain", 20);
        chk("t2_r36", 64'(last_out), 64'h1000_000F);
        push(32'h0000_00F1, 32'd0, 1'b0, 1'b0);
        drain("t2c_drain", 20);
        chk("t2_r0", 64'(last_out), 64'h0000_00F1);
        push(32'h8000_0001, 32'd31, 1'b1, 1'b0);
        drain("t3_drain", 20);
        chk("t3_l31", 64'(last_out), 64'hC000_0000);

        // 200 random beats back to back: one accept per cycle
        for (int i = 0; i < 200; i++)
            push($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        n = 0;
        while (src_q.size() > 0 && n < 400) begin
            tick();
            n++;
        end
        chk("t3_throughput", 64'(n), 64'd200);
        drain("t3_drain_rand", 20);

        // Full stall: two beats held, the rest back-pressured
        rdy_fix = 0; chk_lat = 0;
        for (int i = 0; i < 4; i++) push($urandom, $urandom, 1'($urandom_range(1)), i == 3);
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        chk("t4_s_ready", 64'(s_ready), 64'd0);
        chk("t4_in_flight", 64'(in_flight), 64'd2);
        chk("t4_pending", 64'(src_q.size()), 64'd2);
        @(posedge clk); #1; cyc++;
        rdy_fix = 1;
        drain("t4_drain", 40);

        // Random valid/ready toggling, last every 8th beat
        vmode = 1; rmode = 1;
        for (int i = 0; i < 120; i++) push($urandom, $urandom, 1'($urandom_range(1)), (i % 8) == 7);
        drain("t5_drain", 3000);
        vmode = 0; rmode = 0;

        // Reset with two beats in flight
        rdy_fix = 0;
        push($urandom, $urandom, 1'b0, 1'b0);
        push($urandom, $urandom, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        rstn = 1'b0;
        #1;
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_in_flight", 64'(in_flight), 64'd0);
        exp_q.delete(); src_q.delete(); hold_prev = 0;
        @(posedge clk); #1; cyc++;
        rstn = 1'b1; rdy_fix = 1; chk_lat = 1;
        @(negedge clk);
        chk("t6_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1; cyc++;
        push(32'h1234_5678, 32'd8, 1'b0, 1'b1);
        drain("t6_drain", 20);
        chk("t6_r8", 64'(last_out), 64'h7812_3456);
        for (int i = 0; i < 3; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
